// File: rtl/logic_cluster_pkg.sv
// Shared types and sizing helpers for the logic cluster.
// LOGIC_CLUSTER_CARRY_EN widens each BLE config word by one carry-mode bit.
package logic_cluster_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } lc_state_e;

    function automatic int ble_w(input int k);
`ifdef LOGIC_CLUSTER_CARRY_EN
        return (1 << k) + 2;
`else
        return (1 << k) + 1;
`endif
    endfunction

    function automatic int cfg_bits(input int k, input int n);
        return n * ble_w(k);
    endfunction

endpackage

// File: rtl/logic_cluster_if.sv
// Bundle of the cluster's data, config-chain and carry signals.
// LOGIC_CLUSTER_CARRY_EN adds cin/cout.
interface logic_cluster_if
    import logic_cluster_pkg::*;
#(
    parameter int K = 4,
    parameter int N = 4
) ();
    // cfg_shift is a level qualifier, not a handshake: every high cycle moves one
    // bit of cfg_in into the chain, and the first low cycle ends the load.
    logic [N*K-1:0] lut_in;
    logic           ff_en;
    logic           cfg_shift;
    logic           cfg_in;
    logic           cfg_out;
    logic           cfg_done;
    logic           cfg_err;
    logic [N-1:0]   lc_out;
    lc_state_e      state;
`ifdef LOGIC_CLUSTER_CARRY_EN
    logic           cin;
    logic           cout;
`endif

    modport master (
        output lut_in, ff_en, cfg_shift, cfg_in,
`ifdef LOGIC_CLUSTER_CARRY_EN
        output cin,
        input  cout,
`endif
        input  cfg_out, cfg_done, cfg_err, lc_out, state
    );

    modport slave (
        input  lut_in, ff_en, cfg_shift, cfg_in,
`ifdef LOGIC_CLUSTER_CARRY_EN
        input  cin,
        output cout,
`endif
        output cfg_out, cfg_done, cfg_err, lc_out, state
    );

endinterface

// File: rtl/logic_cluster_ble.sv
// One basic logic element: K-input LUT, optional output register and,
// with LOGIC_CLUSTER_CARRY_EN, a propagate/generate carry cell.
module logic_cluster_ble
    import logic_cluster_pkg::*;
#(
    parameter int K = 4,
    parameter int W = ble_w(K)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [K-1:0] i_in,
    input  logic [W-1:0] i_cfg,
    input  logic         i_clr,
    input  logic         i_en,
`ifdef LOGIC_CLUSTER_CARRY_EN
    input  logic         i_cin,
    output logic         o_cout,
`endif
    output logic         o_out
);
    localparam int T = 1 << K;

    logic [T-1:0] w_table;
    logic         w_lut;
    logic         w_reg_sel;
    logic         w_d;
    logic         r_q;

    assign w_table   = i_cfg[T-1:0];
    assign w_lut     = w_table[i_in];
    assign w_reg_sel = i_cfg[T];

`ifdef LOGIC_CLUSTER_CARRY_EN
    logic w_carry_mode;
    assign w_carry_mode = i_cfg[T+1];
    // In carry mode the LUT supplies propagate; generate comes straight from input 0.
    assign w_d    = w_carry_mode ? (w_lut ^ i_cin) : w_lut;
    assign o_cout = w_carry_mode ? (w_lut ? i_cin : i_in[0]) : i_cin;
`else
    assign w_d = w_lut;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= 1'b0;
        end else if (i_clr) begin
            r_q <= 1'b0;
        end else if (i_en) begin
            r_q <= w_d;
        end
    end

    assign o_out = w_reg_sel ? r_q : w_d;

endmodule

// File: rtl/logic_cluster.sv
// Logic cluster top: N BLEs fed by a serial config shift chain and a
// load/run FSM that validates bitstream length. Optional LOGIC_CLUSTER_CARRY_EN.
module logic_cluster
    import logic_cluster_pkg::*;
#(
    parameter int K = 4,
    parameter int N = 4
) (
    input logic            clk,
    input logic            reset,
    logic_cluster_if.slave bus
);
    localparam int W        = ble_w(K);
    localparam int CFG_BITS = cfg_bits(K, N);
    localparam int CW       = $clog2(CFG_BITS + 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(CFG_BITS);
    localparam logic [CW-1:0] CNT_SAT  = CW'(CFG_BITS + 1);

    lc_state_e            r_state;
    lc_state_e            w_state_next;
    logic [CW-1:0]        r_count;
    logic [CW-1:0]        w_count_next;
    logic                 r_cfg_err;
    logic                 w_err_next;
    logic                 w_clr;
    logic                 w_run;
    logic                 w_ble_en;
    logic [CFG_BITS-1:0]  r_chain;
    logic                 r_cfg_out;
    logic [N-1:0]         w_ble_out;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_count   <= '0;
            r_cfg_err <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_count   <= w_count_next;
            r_cfg_err <= w_err_next;
        end
    end

    // The counter reads 1 after the entry cycle because that cycle already shifts a bit.
    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        w_err_next   = 1'b0;
        w_clr        = 1'b0;
        case (r_state)
            ST_IDLE, ST_RUN: begin
                if (bus.cfg_shift) begin
                    w_state_next = ST_LOAD;
                    w_count_next = CW'(1);
                    w_clr        = 1'b1;
                end
            end
            ST_LOAD: begin
                if (bus.cfg_shift) begin
                    w_count_next = (r_count == CNT_SAT) ? CNT_SAT : r_count + CW'(1);
                end else if (r_count == CNT_FULL) begin
                    w_state_next = ST_RUN;
                end else begin
                    w_state_next = ST_IDLE;
                    w_err_next   = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_chain   <= '0;
            r_cfg_out <= 1'b0;
        end else begin
            if (bus.cfg_shift) begin
                r_chain <= {bus.cfg_in, r_chain[CFG_BITS-1:1]};
            end
            r_cfg_out <= r_chain[0];
        end
    end

    assign w_run    = (r_state == ST_RUN);
    assign w_ble_en = w_run && bus.ff_en;

`ifdef LOGIC_CLUSTER_CARRY_EN
    logic [N:0] w_carry;
    assign w_carry[0] = bus.cin;
    assign bus.cout   = w_run ? w_carry[N] : 1'b0;
`endif

    for (genvar gi = 0; gi < N; gi++) begin : g_ble
        logic_cluster_ble #(
            .K (K),
            .W (W)
        ) u_ble (
            .clk    (clk),
            .reset  (reset),
            .i_in   (bus.lut_in[gi*K +: K]),
            .i_cfg  (r_chain[gi*W +: W]),
            .i_clr  (w_clr),
            .i_en   (w_ble_en),
`ifdef LOGIC_CLUSTER_CARRY_EN
            .i_cin  (w_carry[gi]),
            .o_cout (w_carry[gi+1]),
`endif
            .o_out  (w_ble_out[gi])
        );
    end

    assign bus.lc_out   = w_run ? w_ble_out : '0;
    assign bus.cfg_out  = r_cfg_out;
    assign bus.cfg_done = w_run;
    assign bus.cfg_err  = r_cfg_err;
    assign bus.state    = r_state;

endmodule

// File: tb/tb_logic_cluster.sv
// Directed bench for logic_cluster (K=4, N=4); carry cases run when
// LOGIC_CLUSTER_CARRY_EN is defined.
module tb_logic_cluster;
    import logic_cluster_pkg::*;

    localparam int K   = 4;
    localparam int N   = 4;
    localparam int W   = ble_w(K);
    localparam int CFG = cfg_bits(K, N);

    logic clk   = 1'b0;
    logic reset = 1'b1;

    logic_cluster_if #(.K(K), .N(N)) bus ();

    logic_cluster #(.K(K), .N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    logic [CFG-1:0] base_cfg;
    logic [127:0]   pat;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic shift_bits(input logic [127:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            bus.cfg_shift = 1'b1;
            bus.cfg_in    = bits[i];
            tick();
        end
        bus.cfg_shift = 1'b0;
        bus.cfg_in    = 1'b0;
    endtask

    task automatic test_reset();
        bus.lut_in = '1;
        #1;
        vectors++;
        if (bus.lc_out !== 4'h0) begin
            miscompares++; $display("FAIL reset_lc_out got %h exp 0", bus.lc_out);
        end
        vectors++;
        if (bus.cfg_out !== 1'b0 || bus.cfg_done !== 1'b0 || bus.cfg_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_cfg got out=%b done=%b err=%b exp 000", bus.cfg_out, bus.cfg_done, bus.cfg_err);
        end
        vectors++;
        if (bus.state !== ST_IDLE) begin
            miscompares++; $display("FAIL reset_state got %0d exp %0d", bus.state, ST_IDLE);
        end
`ifdef LOGIC_CLUSTER_CARRY_EN
        vectors++;
        if (bus.cout !== 1'b0) begin
            miscompares++; $display("FAIL reset_cout got %b exp 0", bus.cout);
        end
`endif
        bus.lut_in = '0;
    endtask

    task automatic test_comb();
        base_cfg = '0;
        base_cfg[0*W +: 16] = 16'h8000;
        base_cfg[0*W + 16]  = 1'b0;
        base_cfg[1*W +: 16] = 16'h6996;
        base_cfg[1*W + 16]  = 1'b1;
        shift_bits(128'(base_cfg), CFG);
        vectors++;
        if (bus.cfg_done !== 1'b0) begin
            miscompares++; $display("FAIL load_done_early got %b exp 0", bus.cfg_done);
        end
        tick();
        vectors++;
        if (bus.cfg_done !== 1'b1 || bus.cfg_err !== 1'b0 || bus.state !== ST_RUN) begin
            miscompares++;
            $display("FAIL load_done got done=%b err=%b state=%0d exp 1 0 %0d", bus.cfg_done, bus.cfg_err, bus.state, ST_RUN);
        end
        bus.lut_in = 16'h000F;
        #1;
        vectors++;
        if (bus.lc_out !== 4'b0001) begin
            miscompares++; $display("FAIL and4_hit got %b exp 0001", bus.lc_out);
        end
        bus.lut_in = 16'h000E;
        #1;
        vectors++;
        if (bus.lc_out !== 4'b0000) begin
            miscompares++; $display("FAIL and4_miss got %b exp 0000", bus.lc_out);
        end
    endtask

    task automatic test_registered();
        bus.ff_en  = 1'b1;
        bus.lut_in = 16'h0010;
        #1;
        vectors++;
        if (bus.lc_out !== 4'b0000) begin
            miscompares++; $display("FAIL reg_before_edge got %b exp 0000", bus.lc_out);
        end
        tick();
        vectors++;
        if (bus.lc_out !== 4'b0010) begin
            miscompares++; $display("FAIL reg_capture got %b exp 0010", bus.lc_out);
        end
        bus.ff_en  = 1'b0;
        bus.lut_in = 16'h0030;
        tick();
        vectors++;
        if (bus.lc_out !== 4'b0010) begin
            miscompares++; $display("FAIL reg_hold got %b exp 0010", bus.lc_out);
        end
        bus.ff_en = 1'b1;
        tick();
        vectors++;
        if (bus.lc_out !== 4'b0000) begin
            miscompares++; $display("FAIL reg_update got %b exp 0000", bus.lc_out);
        end
        bus.lut_in = 16'h007F;
        tick();
        vectors++;
        if (bus.lc_out !== 4'b0011) begin
            miscompares++; $display("FAIL reg_and_comb got %b exp 0011", bus.lc_out);
        end
        bus.ff_en = 1'b0;
    endtask

    task automatic test_bad_len();
        int lens[2];
        lens[0] = 40;
        lens[1] = CFG + 2;
        for (int k = 0; k < 2; k++) begin
            bus.lut_in = '1;
            shift_bits(128'hA5A5_5A5A_F0F0_0F0F_1234_5678_9ABC_DEF0, lens[k]);
            vectors++;
            if (bus.cfg_err !== 1'b0) begin
                miscompares++; $display("FAIL bad_len_err_early n=%0d got %b exp 0", lens[k], bus.cfg_err);
            end
            tick();
            vectors++;
            if (bus.cfg_err !== 1'b1 || bus.cfg_done !== 1'b0 || bus.lc_out !== 4'h0 || bus.state !== ST_IDLE) begin
                miscompares++;
                $display("FAIL bad_len n=%0d got err=%b done=%b lc=%h state=%0d exp 1 0 0 %0d",
                         lens[k], bus.cfg_err, bus.cfg_done, bus.lc_out, bus.state, ST_IDLE);
            end
            tick();
            vectors++;
            if (bus.cfg_err !== 1'b0) begin
                miscompares++; $display("FAIL bad_len_pulse n=%0d got %b exp 0", lens[k], bus.cfg_err);
            end
        end
        bus.lut_in = '0;
    endtask

    task automatic test_passthrough();
        int n;
        n   = CFG + 8;
        pat = 128'h0000_0000_0000_0000_C3A5_96F0_0F69_5AB7;
        pat[CFG +: 8] = 8'b1011_0010;
        for (int j = 1; j <= n; j++) begin
            bus.cfg_shift = 1'b1;
            bus.cfg_in    = pat[j-1];
            tick();
            if (j >= CFG + 1) begin
                vectors++;
                if (bus.cfg_out !== pat[j-CFG-1]) begin
                    miscompares++; $display("FAIL passthru edge=%0d got %b exp %b", j, bus.cfg_out, pat[j-CFG-1]);
                end
            end
        end
        bus.cfg_shift = 1'b0;
        bus.cfg_in    = 1'b0;
        tick();
        vectors++;
        if (bus.cfg_out !== pat[n-CFG] || bus.cfg_err !== 1'b1) begin
            miscompares++;
            $display("FAIL passthru_tail got out=%b err=%b exp %b 1", bus.cfg_out, bus.cfg_err, pat[n-CFG]);
        end
        tick();
    endtask

    task automatic test_reset_mid_load();
        for (int i = 0; i < 30; i++) begin
            bus.cfg_shift = 1'b1;
            bus.cfg_in    = base_cfg[i];
            tick();
        end
        reset = 1'b1;
        #1;
        vectors++;
        if (bus.state !== ST_IDLE || bus.cfg_out !== 1'b0 || bus.cfg_done !== 1'b0 || bus.cfg_err !== 1'b0) begin
            miscompares++;
            $display("FAIL midload_reset got state=%0d out=%b done=%b err=%b exp %0d 0 0 0",
                     bus.state, bus.cfg_out, bus.cfg_done, bus.cfg_err, ST_IDLE);
        end
        bus.cfg_shift = 1'b0;
        bus.cfg_in    = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        tick();
        vectors++;
        if (bus.cfg_err !== 1'b0 || bus.state !== ST_IDLE || bus.cfg_out !== 1'b0) begin
            miscompares++;
            $display("FAIL midload_after got err=%b state=%0d out=%b exp 0 %0d 0", bus.cfg_err, bus.state, bus.cfg_out, ST_IDLE);
        end
        shift_bits(128'(base_cfg), CFG);
        tick();
        bus.lut_in = 16'h000F;
        #1;
        vectors++;
        if (bus.cfg_done !== 1'b1 || bus.lc_out !== 4'b0001) begin
            miscompares++; $display("FAIL reload got done=%b lc=%b exp 1 0001", bus.cfg_done, bus.lc_out);
        end
        bus.lut_in = '0;
    endtask

`ifdef LOGIC_CLUSTER_CARRY_EN
    task automatic apply_add(input logic [3:0] a, input logic [3:0] b, input logic ci,
                             input logic [3:0] exp_sum, input logic exp_co);
        bus.lut_in = '0;
        for (int i = 0; i < N; i++) begin
            bus.lut_in[i*K + 0] = a[i];
            bus.lut_in[i*K + 1] = b[i];
        end
        bus.cin = ci;
        #1;
        vectors++;
        if (bus.lc_out !== exp_sum || bus.cout !== exp_co) begin
            miscompares++;
            $display("FAIL carry a=%h b=%h cin=%b got %h/%b exp %h/%b", a, b, ci, bus.lc_out, bus.cout, exp_sum, exp_co);
        end
    endtask

    task automatic test_carry();
        logic [CFG-1:0] ccfg;
        ccfg = '0;
        for (int i = 0; i < N; i++) begin
            ccfg[i*W +: 16] = 16'h6666;
            ccfg[i*W + 17]  = 1'b1;
        end
        shift_bits(128'(ccfg), CFG);
        tick();
        vectors++;
        if (bus.cfg_done !== 1'b1) begin
            miscompares++; $display("FAIL carry_load got %b exp 1", bus.cfg_done);
        end
        apply_add(4'h7, 4'h1, 1'b0, 4'h8, 1'b0);
        apply_add(4'hF, 4'h0, 1'b1, 4'h0, 1'b1);
        apply_add(4'h5, 4'h3, 1'b1, 4'h9, 1'b0);
        apply_add(4'hC, 4'h6, 1'b0, 4'h2, 1'b1);
    endtask
`endif

    initial begin
        bus.lut_in    = '0;
        bus.ff_en     = 1'b0;
        bus.cfg_shift = 1'b0;
        bus.cfg_in    = 1'b0;
`ifdef LOGIC_CLUSTER_CARRY_EN
        bus.cin       = 1'b0;
`endif
        reset = 1'b1;
        tick();
        test_reset();
        tick();
        reset = 1'b0;
        tick();
        test_comb();
        test_registered();
        test_bad_len();
        test_passthrough();
        test_reset_mid_load();
`ifdef LOGIC_CLUSTER_CARRY_EN
        test_carry();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
